// File: rtl/program_memory_loadable_pkg.sv
// program_memory_loadable_pkg: shared state encodings and default filler word
package program_memory_loadable_pkg;
    typedef enum logic [1:0] {
        PM_IDLE = 2'd0,
        PM_LOAD = 2'd1,
        PM_DONE = 2'd2
    } pm_state_t;
    localparam logic [29:0] PM_FILL_WORD = 30'h000000AA;
endpackage

// File: rtl/program_memory_loadable_if.sv
// program_memory_loadable_if: fetch and program-load signals of the program memory
interface program_memory_loadable_if #(
    parameter int DATA_WIDTH = 30,
    parameter int ADDR_WIDTH = 16
) ();
    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  valid;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  busy;
    logic                  load_start;
    logic [ADDR_WIDTH-1:0] load_base;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  load_ready;
    logic                  load_done;
    logic                  load_error;
    modport master (
        output req, addr, load_start, load_base, load_valid, load_data, load_last,
        input  valid, instruction, busy, load_ready, load_done, load_error
    );
    modport slave (
        input  req, addr, load_start, load_base, load_valid, load_data, load_last,
        output valid, instruction, busy, load_ready, load_done, load_error
    );
endinterface

// File: rtl/program_memory_loadable_ram.sv
// program_ram_sdp: simple dual-port RAM, one write port and one registered read port
module program_ram_sdp #(
    parameter int DATA_WIDTH = 30,
    parameter int DEPTH      = 256,
    parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    // write port plus read register that holds its value between reads
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/program_memory_loadable.sv
// program_memory_loadable: loadable program RAM with registered fetch and streaming load port
module program_memory_loadable
    import program_memory_loadable_pkg::*;
#(
    parameter int                    DATA_WIDTH = 30,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = PM_FILL_WORD
) (
    input logic                       clk,
    input logic                       rst,
    program_memory_loadable_if.slave  bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

    pm_state_t             state, state_nx;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DEPTH-1:0]      written;
    logic                  valid_q, hit_q, error_q;
    logic                  fetch, fetch_in, accept, ptr_in;
    logic [DATA_WIDTH-1:0] rdata;

    assign fetch    = (state == PM_IDLE) && bus.req;
    assign fetch_in = 32'(bus.addr) < DEPTH;
    assign accept   = (state == PM_LOAD) && bus.load_valid;
    assign ptr_in   = 32'(ptr) < DEPTH;

    program_ram_sdp #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(IW)) u_ram (
        .clk   (clk),
        .we    (accept && ptr_in),
        .waddr (ptr[IW-1:0]),
        .wdata (bus.load_data),
        .re    (fetch && fetch_in),
        .raddr (bus.addr[IW-1:0]),
        .rdata (rdata)
    );

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? PM_IDLE : state_nx;
    end

    // next state and Moore outputs; unwritten words are masked to the filler
    always_comb begin
        state_nx        = state;
        bus.busy        = state != PM_IDLE;
        bus.load_ready  = state == PM_LOAD;
        bus.load_done   = state == PM_DONE;
        bus.load_error  = error_q;
        bus.valid       = valid_q;
        bus.instruction = hit_q ? rdata : FILL_WORD;
        state_nx = (state == PM_IDLE) ? (bus.load_start ? PM_LOAD : PM_IDLE) :
                   (state == PM_LOAD) ? ((accept && bus.load_last) ? PM_DONE : PM_LOAD) :
                   PM_IDLE;
    end

    // load pointer with saturation and sticky out-of-range error
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            error_q <= 1'b0;
        end else if ((state == PM_IDLE) && bus.load_start) begin
            ptr     <= bus.load_base;
            error_q <= 1'b0;
        end else if (accept) begin
            ptr     <= (ptr == PTR_MAX) ? ptr : ptr + 1'b1;
            error_q <= error_q | !ptr_in | (ptr == PTR_MAX);
        end
    end

    // written-word bitmap; clearing it invalidates the whole program
    always_ff @(posedge clk) begin
        if (rst) written <= '0;
        else if (accept && ptr_in) written[ptr[IW-1:0]] <= 1'b1;
    end

    // fetch response flags, hit selects RAM data over the filler
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            valid_q <= fetch;
            if (fetch) hit_q <= fetch_in && written[bus.addr[IW-1:0]];
        end
    end
endmodule

// File: tb/tb_program_memory_loadable.sv
// tb_program_memory_loadable: directed bench with a transaction-level program model
module tb_program_memory_loadable;
    localparam logic [29:0] FILL = 30'h000000AA;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    program_memory_loadable_if #(.DATA_WIDTH(30), .ADDR_WIDTH(16)) pif ();

    program_memory_loadable dut (
        .clk (clk),
        .rst (rst),
        .bus (pif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // model: program image as an associative array, mode 0 idle / 1 loading / 2 finishing
    logic [29:0] prog [int];
    int          m_mode = 0;
    int          m_ptr = 0;
    logic        m_err = 1'b0;
    logic        m_valid = 1'b0;
    logic [29:0] m_instr = FILL;
    logic        armed = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            armed = 1'b1;
            m_mode = 0;
            m_err = 1'b0;
            m_valid = 1'b0;
            m_instr = FILL;
            prog.delete();
        end else if (m_mode == 0) begin
            m_valid = pif.req;
            if (pif.req) m_instr = prog.exists(int'(pif.addr)) ? prog[int'(pif.addr)] : FILL;
            if (pif.load_start) begin
                m_mode = 1;
                m_ptr = int'(pif.load_base);
                m_err = 1'b0;
            end
        end else if (m_mode == 1) begin
            m_valid = 1'b0;
            if (pif.load_valid) begin
                if (m_ptr < 256) prog[m_ptr] = pif.load_data;
                else m_err = 1'b1;
                if (m_ptr == 65535) m_err = 1'b1;
                else m_ptr = m_ptr + 1;
                if (pif.load_last) m_mode = 2;
            end
        end else begin
            m_valid = 1'b0;
            m_mode = 0;
        end
    end

    // compare every cycle once the model has seen reset
    always @(posedge clk) begin
        #1;
        if (armed) begin
            chk("valid", 32'(pif.valid), 32'(m_valid));
            chk("instruction", 32'(pif.instruction), 32'(m_instr));
            chk("busy", 32'(pif.busy), 32'(m_mode != 0));
            chk("load_ready", 32'(pif.load_ready), 32'(m_mode == 1));
            chk("load_done", 32'(pif.load_done), 32'(m_mode == 2));
            chk("load_error", 32'(pif.load_error), 32'(m_err));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic quiet();
        pif.req = 1'b0;
        pif.addr = '0;
        pif.load_start = 1'b0;
        pif.load_base = '0;
        pif.load_valid = 1'b0;
        pif.load_data = '0;
        pif.load_last = 1'b0;
    endtask

    task automatic fetch(input int a);
        pif.req = 1'b1;
        pif.addr = 16'(a);
        tick();
        pif.req = 1'b0;
    endtask

    task automatic start(input int base);
        pif.load_start = 1'b1;
        pif.load_base = 16'(base);
        tick();
        pif.load_start = 1'b0;
    endtask

    task automatic word(input logic [29:0] d, input logic last);
        pif.load_valid = 1'b1;
        pif.load_data = d;
        pif.load_last = last;
        tick();
        pif.load_valid = 1'b0;
        pif.load_last = 1'b0;
    endtask

    initial begin
        quiet();
        tick();
        tick();
        chk("reset_instr", 32'(pif.instruction), 32'(FILL));
        chk("reset_busy", 32'(pif.busy), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pif.req = 1'b1;
            pif.addr = 16'(i);
            tick();
            chk("empty_fetch", 32'(pif.instruction), 32'(FILL));
            chk("empty_valid", 32'(pif.valid), 32'd1);
        end
        pif.req = 1'b0;
        tick();
        chk("idle_valid", 32'(pif.valid), 32'd0);

        start(10);
        word(30'h1, 1'b0);
        word(30'h2, 1'b0);
        word(30'h3, 1'b1);
        chk("done_pulse", 32'(pif.load_done), 32'd1);
        chk("done_busy", 32'(pif.busy), 32'd1);
        tick();
        chk("after_done_busy", 32'(pif.busy), 32'd0);
        chk("clean_error", 32'(pif.load_error), 32'd0);
        for (int i = 10; i < 14; i++) fetch(i);
        fetch(11);
        chk("word11", 32'(pif.instruction), 32'h2);
        fetch(13);
        chk("word13", 32'(pif.instruction), 32'(FILL));

        start(254);
        for (int i = 0; i < 4; i++) word(30'(32'h100 + i), i == 3);
        tick();
        chk("overrun_error", 32'(pif.load_error), 32'd1);
        fetch(254);
        chk("word254", 32'(pif.instruction), 32'h100);
        fetch(255);
        fetch(256);
        chk("word256", 32'(pif.instruction), 32'(FILL));
        chk("error_sticky", 32'(pif.load_error), 32'd1);

        pif.req = 1'b1;
        pif.addr = 16'd12;
        pif.load_start = 1'b1;
        pif.load_base = 16'd30;
        tick();
        pif.load_start = 1'b0;
        chk("same_cycle_fetch", 32'(pif.instruction), 32'h3);
        chk("same_cycle_valid", 32'(pif.valid), 32'd1);
        chk("error_cleared", 32'(pif.load_error), 32'd0);
        word(30'h3A, 1'b0);
        tick();
        word(30'h3B, 1'b1);
        tick();
        pif.req = 1'b0;
        tick();

        start(20);
        word(30'h20, 1'b0);
        word(30'h21, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_reset_busy", 32'(pif.busy), 32'd0);
        fetch(20);
        chk("mid_reset_fetch", 32'(pif.instruction), 32'(FILL));
        fetch(10);

        start(40);
        word(30'h11, 1'b0);
        tick();
        tick();
        word(30'h22, 1'b1);
        tick();
        fetch(40);
        fetch(41);
        chk("stall_word41", 32'(pif.instruction), 32'h22);
        fetch(42);
        chk("stall_word42", 32'(pif.instruction), 32'(FILL));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
